gb_oam_dma: RTL and testbench

GB_OAM_DMA -- requirements
Module: gb_oam_dma

---
 rtl/gb_dma_pkg.sv | 25 ++
 rtl/gb_oam_dma.sv | 121 ++++++++++++
 tb/tb_gb_oam_dma.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_dma_pkg.sv
// Shared definitions for the Game Boy OAM DMA block: FSM encoding,
// high-RAM window bounds and the echo-RAM source offset.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_t;

    // High RAM stays reachable by the CPU while a transfer owns the bus.
    localparam logic [15:0] HRAM_LO = 16'hFF80;
    localparam logic [15:0] HRAM_HI = 16'hFFFE;

    // Source pages E0-FF mirror C0-DF (echo RAM).
    localparam logic [7:0] ECHO_LIMIT  = 8'hDF;
    localparam logic [7:0] ECHO_OFFSET = 8'h20;

    // Map the programmed source page onto the page actually fetched.
    function automatic logic [7:0] src_effective(input logic [7:0] src);
        return (src > ECHO_LIMIT) ? (src - ECHO_OFFSET) : src;
    endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: a write to the source register copies LENGTH bytes from
// page {src,00} into OAM, one byte per READ/WRITE cycle pair. While the
// copy runs the engine owns the shared bus and the CPU is limited to HRAM.
//
// Bus/OAM signalling is single-cycle strobe based: a strobe (bus_read,
// bus_write, oam_write, cpu_read, cpu_write) high in a cycle means the
// address/data presented in that same cycle are valid for that cycle only;
// there is no back-pressure, and read data on bus_din is taken at the end
// of the cycle in which bus_read is high.
module gb_oam_dma
    import gb_dma_pkg::*;
#(
    parameter logic [15:0] REG_ADR = 16'hFF46,
    parameter int          LENGTH  = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_adr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_din,
    output logic        oam_write,
    output logic        dma_active,
    output logic        cpu_blocked,
    output logic [7:0]  reg_dout,
    output logic        reg_drv,
    output dma_state_t  dbg_state
);

    localparam logic [7:0] IDX_LAST = 8'(LENGTH - 1);

    dma_state_t  r_state;
    logic [7:0]  r_src;
    logic [7:0]  r_idx;
    logic [7:0]  r_data;

    logic        w_reg_wr;
    logic        w_dma_owns;
    logic        w_in_hram;
    logic [7:0]  w_src_eff;

    assign w_reg_wr   = cpu_write && (cpu_adr == REG_ADR);
    assign w_dma_owns = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign w_in_hram  = (cpu_adr >= HRAM_LO) && (cpu_adr <= HRAM_HI);
    assign w_src_eff  = src_effective(r_src);

    // Transfer FSM with source register, byte index and fetched-data latch.
    // A register write restarts from any state; reset overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_src   <= 8'h00;
            r_idx   <= 8'h00;
            r_data  <= 8'h00;
        end else if (w_reg_wr) begin
            r_state <= ST_START;
            r_src   <= cpu_dout;
            r_idx   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_START: begin
                    r_state <= ST_READ;
                end
                ST_READ: begin
                    r_data  <= bus_din;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Hold idx on the final byte so it never runs past LENGTH-1.
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ST_READ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus arbitration: DMA drives a read-only fetch in READ/WRITE, CPU passes through otherwise.
    always_comb begin
        bus_adr   = cpu_adr;
        bus_read  = cpu_read;
        bus_write = cpu_write;
        if (w_dma_owns) begin
            bus_adr   = {w_src_eff, r_idx};
            bus_read  = 1'b1;
            bus_write = 1'b0;
        end
    end

    // OAM write port and status decoded straight from the registered state.
    always_comb begin
        oam_write  = (r_state == ST_WRITE);
        oam_adr    = r_idx;
        oam_din    = r_data;
        dma_active = (r_state != ST_IDLE);
        dbg_state  = r_state;
    end

    // CPU access gating and source-register readback.
    always_comb begin
        cpu_blocked = w_dma_owns && (cpu_read || cpu_write) && !w_in_hram;
        reg_drv     = cpu_read && (cpu_adr == REG_ADR) && !cpu_blocked;
        reg_dout    = r_src;
    end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Directed bench for gb_oam_dma. Every OAM write the DUT makes is matched
// against a queue of {cycle, oam_adr, oam_din} entries pushed when each
// transfer is started; directed point checks cover arbitration and reset.
module tb_gb_oam_dma;
    import gb_dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dout;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  bus_din;
    logic [15:0] bus_adr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_din;
    logic        oam_write;
    logic        dma_active;
    logic        cpu_blocked;
    logic [7:0]  reg_dout;
    logic        reg_drv;
    dma_state_t  dbg_state;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          t;
    logic [31:0] exp_q[$];

    gb_oam_dma dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_adr     (cpu_adr),
        .cpu_dout    (cpu_dout),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .bus_din     (bus_din),
        .bus_adr     (bus_adr),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .oam_adr     (oam_adr),
        .oam_din     (oam_din),
        .oam_write   (oam_write),
        .dma_active  (dma_active),
        .cpu_blocked (cpu_blocked),
        .reg_dout    (reg_dout),
        .reg_drv     (reg_drv),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: page C1 holds i^5A; other pages are distinguished by their page byte.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'hC1);
    endfunction

    assign bus_din = pat(bus_adr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the rising edge that starts cycle c.
    task automatic goto(input int c);
        if (cyc > c) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: at cycle %0d expected to reach %0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Expected OAM writes for a transfer whose register write is in cycle t0.
    task automatic push_xfer(input int t0, input logic [7:0] page, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({16'(t0 + 3 + 2 * k), 8'(k), pat({page, 8'(k)})});
        end
    endtask

    task automatic reg_write(input logic [7:0] v);
        cpu_read  = 1'b0;
        cpu_write = 1'b1;
        cpu_adr   = 16'hFF46;
        cpu_dout  = v;
    endtask

    task automatic idle_cpu();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_adr   = 16'h0000;
        cpu_dout  = 8'h00;
    endtask

    // Scoreboard monitor: every OAM write must match the head of the queue.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (oam_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL oam_unexpected: got adr %h din %h with empty queue (cycle %0d)",
                         oam_adr, oam_din, cyc);
            end else begin
                e = exp_q.pop_front();
                check("oam_write {cyc,adr,din}", {cyc[15:0], oam_adr, oam_din}, e);
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        n_err++;
        $display("FAIL timeout: simulation exceeded cycle budget at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle_cpu();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        sample();
        check("rst dma_active", 32'(dma_active), 32'd0);
        check("rst oam_write", 32'(oam_write), 32'd0);
        check("rst cpu_blocked", 32'(cpu_blocked), 32'd0);
        check("rst reg_drv", 32'(reg_drv), 32'd0);
        check("rst reg_dout", 32'(reg_dout), 32'h00);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));

        goto(cyc + 1);
        cpu_read = 1'b1;
        cpu_adr  = 16'hFF46;
        sample();
        check("idle reg_drv", 32'(reg_drv), 32'd1);
        check("idle reg_dout", 32'(reg_dout), 32'h00);
        check("idle bus_adr pass", 32'(bus_adr), 32'hFF46);
        check("idle bus_read pass", 32'(bus_read), 32'd1);

        // Transfer from C1 with arbitration checks.
        goto(cyc + 1);
        t = cyc;
        reg_write(8'hC1);
        push_xfer(t, 8'hC1, 160);
        sample();
        check("A idle bus_write pass", 32'(bus_write), 32'd1);
        goto(t + 1);
        cpu_write = 1'b0;
        cpu_read  = 1'b1;
        cpu_adr   = 16'h1234;
        sample();
        check("A start dma_active", 32'(dma_active), 32'd1);
        check("A start state", 32'(dbg_state), 32'(ST_START));
        check("A start bus_adr pass", 32'(bus_adr), 32'h1234);
        goto(t + 2);
        idle_cpu();
        sample();
        check("A read bus_adr", 32'(bus_adr), 32'hC100);
        check("A read bus_read", 32'(bus_read), 32'd1);
        check("A read bus_write", 32'(bus_write), 32'd0);
        goto(t + 3);
        sample();
        check("A first oam_write", 32'(oam_write), 32'd1);
        check("A first oam_adr", 32'(oam_adr), 32'h00);
        goto(t + 10);
        cpu_read = 1'b1;
        cpu_adr  = 16'hC000;
        sample();
        check("A blocked C000", 32'(cpu_blocked), 32'd1);
        goto(t + 11);
        cpu_adr = 16'hFF85;
        sample();
        check("A hram FF85", 32'(cpu_blocked), 32'd0);
        goto(t + 12);
        cpu_read  = 1'b0;
        cpu_write = 1'b1;
        cpu_adr   = 16'h8000;
        cpu_dout  = 8'hAA;
        sample();
        check("A blocked write 8000", 32'(cpu_blocked), 32'd1);
        check("A bus_write owned", 32'(bus_write), 32'd0);
        goto(t + 13);
        cpu_write = 1'b0;
        cpu_read  = 1'b1;
        cpu_adr   = 16'hFF46;
        sample();
        check("A reg_drv blocked", 32'(reg_drv), 32'd0);
        goto(t + 14);
        idle_cpu();
        goto(t + 321);
        sample();
        check("A last oam_write", 32'(oam_write), 32'd1);
        check("A last oam_adr", 32'(oam_adr), 32'h9F);
        goto(t + 322);
        sample();
        check("A end dma_active", 32'(dma_active), 32'd0);
        check("A queue drained", 32'(exp_q.size()), 32'd0);

        // Restart: C1 then D0 after 100 cycles.
        goto(cyc + 1);
        t = cyc;
        reg_write(8'hC1);
        push_xfer(t, 8'hC1, 49);
        goto(t + 1);
        idle_cpu();
        goto(t + 100);
        reg_write(8'hD0);
        push_xfer(t + 100, 8'hD0, 160);
        goto(t + 101);
        idle_cpu();
        sample();
        check("B restart state", 32'(dbg_state), 32'(ST_START));
        goto(t + 102);
        sample();
        check("B restart bus_adr", 32'(bus_adr), 32'hD000);
        goto(t + 421);
        sample();
        check("B active before end", 32'(dma_active), 32'd1);
        goto(t + 422);
        sample();
        check("B end dma_active", 32'(dma_active), 32'd0);
        check("B queue drained", 32'(exp_q.size()), 32'd0);

        // Echo source E3 fetches from C3.
        goto(cyc + 1);
        t = cyc;
        reg_write(8'hE3);
        push_xfer(t, 8'hC3, 160);
        goto(t + 1);
        idle_cpu();
        goto(t + 2);
        sample();
        check("C echo bus_adr", 32'(bus_adr), 32'hC300);
        goto(t + 323);
        cpu_read = 1'b1;
        cpu_adr  = 16'hFF46;
        sample();
        check("C reg_drv", 32'(reg_drv), 32'd1);
        check("C reg_dout", 32'(reg_dout), 32'hE3);
        check("C queue drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-transfer at idx 50, with a simultaneous register write.
        goto(t + 324);
        t = cyc;
        reg_write(8'hC1);
        push_xfer(t, 8'hC1, 50);
        goto(t + 1);
        idle_cpu();
        goto(t + 102);
        reset = 1'b1;
        reg_write(8'h55);
        goto(t + 103);
        reset = 1'b0;
        idle_cpu();
        sample();
        check("D reset state", 32'(dbg_state), 32'(ST_IDLE));
        check("D reset dma_active", 32'(dma_active), 32'd0);
        check("D reset oam_write", 32'(oam_write), 32'd0);
        goto(t + 104);
        cpu_read = 1'b1;
        cpu_adr  = 16'hFF46;
        sample();
        check("D reg_drv", 32'(reg_drv), 32'd1);
        check("D reg_dout", 32'(reg_dout), 32'h00);
        goto(t + 110);
        idle_cpu();
        sample();
        check("D stays idle", 32'(dma_active), 32'd0);
        check("D queue drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
